// File: rtl/jpeg_pkg.sv
// Shared JPEG scheduling types: colour modes, block types, FSM encoding and
// the blocks-per-MCU mapping.
package jpeg_pkg;

  typedef enum logic [1:0] {
    JPEG_MONOCHROME  = 2'd0,
    JPEG_YCBCR_444   = 2'd1,
    JPEG_YCBCR_420   = 2'd2,
    JPEG_UNSUPPORTED = 2'd3
  } jpeg_mode_e;

  typedef enum logic [1:0] {
    BLK_Y  = 2'd0,
    BLK_CB = 2'd1,
    BLK_CR = 2'd2
  } blk_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BLOCK = 2'd2,
    ST_FLUSH = 2'd3
  } sched_state_e;

  function automatic logic [2:0] mode_bpm(input jpeg_mode_e mode);
    case (mode)
      JPEG_MONOCHROME: mode_bpm = 3'd1;
      JPEG_YCBCR_444:  mode_bpm = 3'd3;
      JPEG_YCBCR_420:  mode_bpm = 3'd6;
      default:         mode_bpm = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/jpeg_mcu_buf_tracker.sv
// MCU buffer ring bookkeeping: write/read pointers, occupancy and the
// per-buffer end-of-image flag.
module jpeg_mcu_buf_tracker #(
  parameter int NUM_BUFS = 2,
  parameter int BUF_W    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             complete,
  input  logic             complete_last,
  input  logic             release_req,
  output logic [BUF_W-1:0] wr_ptr,
  output logic [BUF_W-1:0] rd_ptr,
  output logic [BUF_W:0]   occ,
  output logic             rd_last
);

  logic [NUM_BUFS-1:0] last;
  logic                do_release;

  // A release against an empty ring is silently dropped.
  assign do_release = release_req && (occ != '0);
  assign rd_last    = last[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      last   <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      last   <= '0;
    end else begin
      if (complete) begin
        wr_ptr       <= wr_ptr + 1'b1;
        last[wr_ptr] <= complete_last;
      end
      if (do_release) rd_ptr <= rd_ptr + 1'b1;
      case ({complete, do_release})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/jpeg_mcu_sched.sv
// MCU scheduler: grants block decode into free buffers and presents full MCUs.
// Optional statistics counters are built when JPEG_MCU_SCHED_STATS_EN is defined.
module jpeg_mcu_sched
  import jpeg_pkg::*;
#(
  parameter int NUM_BUFS = 2,
  parameter int BUF_W    = $clog2(NUM_BUFS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             img_start_i,
  input  logic [1:0]       img_mode_i,
  output logic             dec_ready_o,
  input  logic             dec_start_i,
  input  logic             dec_end_i,
  input  logic             dec_eoi_i,
  output logic [BUF_W-1:0] wr_buf_o,
  output logic [2:0]       wr_slot_o,
  output logic             mcu_valid_o,
  output logic [BUF_W-1:0] mcu_buf_o,
  output logic             mcu_last_o,
  input  logic             mcu_accept_i,
`ifdef JPEG_MCU_SCHED_STATS_EN
  output logic [31:0]      stat_mcus_o,
  output logic [31:0]      stat_stall_o,
`endif
  output logic             err_o,
  output logic             idle_o
);

  localparam logic [BUF_W:0] FULL = NUM_BUFS[BUF_W:0];

  sched_state_e     state, state_nx;
  logic [2:0]       bpm, slot, slot_nx;
  logic             err, idle;
  logic             clear, complete, proto_err, mcu_done, mode_bad;
  logic [BUF_W-1:0] wr_ptr, rd_ptr;
  logic [BUF_W:0]   occ;
  logic             rd_last;

  jpeg_mcu_buf_tracker #(
    .NUM_BUFS(NUM_BUFS),
    .BUF_W   (BUF_W)
  ) u_tracker (
    .clk          (clk_i),
    .rst_n        (rst_i),
    .clear        (clear),
    .complete     (complete),
    .complete_last(dec_eoi_i),
    .release_req  (mcu_accept_i),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .occ          (occ),
    .rd_last      (rd_last)
  );

  assign mode_bad    = (img_mode_i == JPEG_UNSUPPORTED);
  assign mcu_done    = ((slot + 3'd1) == bpm);
  // Grant uses registered occupancy, so a same-cycle release is seen one cycle later.
  assign dec_ready_o = (state == ST_RUN) && (occ < FULL);
  assign mcu_valid_o = (occ != '0);
  assign mcu_buf_o   = rd_ptr;
  assign mcu_last_o  = mcu_valid_o && rd_last;
  assign wr_buf_o    = wr_ptr;
  assign wr_slot_o   = slot;
  assign err_o       = err;
  assign idle_o      = idle;

  always_comb begin
    state_nx  = state;
    slot_nx   = slot;
    clear     = 1'b0;
    complete  = 1'b0;
    proto_err = 1'b0;
    if (img_start_i) begin
      clear    = 1'b1;
      slot_nx  = '0;
      state_nx = mode_bad ? ST_IDLE : ST_RUN;
    end else begin
      proto_err = (dec_start_i && !dec_ready_o) || (dec_end_i && (state != ST_BLOCK));
      case (state)
        ST_RUN: if (dec_start_i && dec_ready_o) state_nx = ST_BLOCK;
        ST_BLOCK: begin
          if (dec_end_i) begin
            if (mcu_done) begin
              complete = 1'b1;
              slot_nx  = '0;
              state_nx = dec_eoi_i ? ST_FLUSH : ST_RUN;
            end else begin
              slot_nx  = slot + 3'd1;
              state_nx = ST_RUN;
            end
          end
        end
        ST_FLUSH: if (occ == '0) state_nx = ST_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= ST_IDLE;
      slot  <= '0;
      bpm   <= 3'd1;
      err   <= 1'b0;
      idle  <= 1'b1;
    end else begin
      state <= state_nx;
      slot  <= slot_nx;
      idle  <= (state_nx == ST_IDLE);
      if (img_start_i) begin
        bpm <= mode_bpm(jpeg_mode_e'(img_mode_i));
        if (mode_bad)              err <= 1'b1;
        else if (state == ST_IDLE) err <= 1'b0;
      end else if (proto_err) begin
        err <= 1'b1;
      end
    end
  end

`ifdef JPEG_MCU_SCHED_STATS_EN
  logic [31:0] stat_mcus, stat_stall;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stat_mcus  <= '0;
      stat_stall <= '0;
    end else if (img_start_i) begin
      stat_mcus  <= '0;
      stat_stall <= '0;
    end else begin
      if (complete && (stat_mcus != '1)) stat_mcus <= stat_mcus + 32'd1;
      if ((state == ST_RUN) && (occ == FULL) && (stat_stall != '1))
        stat_stall <= stat_stall + 32'd1;
    end
  end

  assign stat_mcus_o  = stat_mcus;
  assign stat_stall_o = stat_stall;
`endif

endmodule

// File: tb/tb_jpeg_mcu_sched.sv
// Directed self-checking bench for jpeg_mcu_sched with two MCU buffers.
module tb_jpeg_mcu_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       img_start = 1'b0;
  logic [1:0] img_mode = 2'd0;
  logic       dec_ready;
  logic       dec_start = 1'b0;
  logic       dec_end = 1'b0;
  logic       dec_eoi = 1'b0;
  logic       wr_buf;
  logic [2:0] wr_slot;
  logic       mcu_valid;
  logic       mcu_buf;
  logic       mcu_last;
  logic       mcu_accept = 1'b0;
  logic       err;
  logic       idle;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  jpeg_mcu_sched #(.NUM_BUFS(2), .BUF_W(1)) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .img_start_i (img_start),
    .img_mode_i  (img_mode),
    .dec_ready_o (dec_ready),
    .dec_start_i (dec_start),
    .dec_end_i   (dec_end),
    .dec_eoi_i   (dec_eoi),
    .wr_buf_o    (wr_buf),
    .wr_slot_o   (wr_slot),
    .mcu_valid_o (mcu_valid),
    .mcu_buf_o   (mcu_buf),
    .mcu_last_o  (mcu_last),
    .mcu_accept_i(mcu_accept),
    .err_o       (err),
    .idle_o      (idle)
  );

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; img_start = 1'b0; dec_start = 1'b0; dec_end = 1'b0;
    dec_eoi = 1'b0; mcu_accept = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic start_img(input logic [1:0] mode);
    img_start = 1'b1; img_mode = mode;
    tick();
    img_start = 1'b0;
  endtask

  task automatic do_block(input logic eoi);
    dec_start = 1'b1;
    tick();
    dec_start = 1'b0; dec_end = 1'b1; dec_eoi = eoi;
    tick();
    dec_end = 1'b0; dec_eoi = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    rst_n = 1'b0;
    repeat (2) tick();
    obs = {dec_ready, wr_buf, wr_slot, mcu_valid, mcu_buf, mcu_last, err, idle};
    n_tests++;
    if (obs !== 10'b0_0_000_0_0_0_0_1) begin n_fail++; $display("FAIL reset_outputs got=%b exp=%b", obs, 10'b0000000001); end
    rst_n = 1'b1;
  endtask

  task automatic test_mono_full();
    do_reset();
    start_img(2'd0);
    n_tests++;
    if (dec_ready !== 1'b1) begin n_fail++; $display("FAIL mono_ready_start got=%b exp=1", dec_ready); end
    do_block(1'b0);
    do_block(1'b0);
    n_tests++;
    if ({dec_ready, mcu_valid, mcu_buf, wr_buf} !== 4'b0100) begin n_fail++; $display("FAIL mono_full got=%b exp=0100", {dec_ready, mcu_valid, mcu_buf, wr_buf}); end
    mcu_accept = 1'b1;
    tick();
    mcu_accept = 1'b0;
    n_tests++;
    if ({dec_ready, mcu_valid, mcu_buf} !== 3'b111) begin n_fail++; $display("FAIL mono_release got=%b exp=111", {dec_ready, mcu_valid, mcu_buf}); end
  endtask

  task automatic test_420_stream();
    int         pulses;
    logic [1:0] pbuf, plast;
    pulses = 0; pbuf = '0; plast = '0;
    do_reset();
    start_img(2'd2);
    mcu_accept = 1'b1;
    for (int i = 0; i < 12; i++) begin
      n_tests++;
      if (wr_slot !== 3'(i % 6)) begin n_fail++; $display("FAIL s420_slot%0d got=%0d exp=%0d", i, wr_slot, i % 6); end
      dec_start = 1'b1;
      tick();
      dec_start = 1'b0;
      if (mcu_valid) begin if (pulses < 2) begin pbuf[pulses] = mcu_buf; plast[pulses] = mcu_last; end pulses++; end
      dec_end = 1'b1; dec_eoi = (i == 11);
      tick();
      dec_end = 1'b0; dec_eoi = 1'b0;
      if (mcu_valid) begin if (pulses < 2) begin pbuf[pulses] = mcu_buf; plast[pulses] = mcu_last; end pulses++; end
    end
    for (int k = 0; k < 8 && !idle; k++) begin
      tick();
      if (mcu_valid) begin if (pulses < 2) begin pbuf[pulses] = mcu_buf; plast[pulses] = mcu_last; end pulses++; end
    end
    mcu_accept = 1'b0;
    n_tests++;
    if (pulses != 2) begin n_fail++; $display("FAIL s420_pulses got=%0d exp=2", pulses); end
    n_tests++;
    if ({pbuf, plast} !== 4'b10_10) begin n_fail++; $display("FAIL s420_bufs_last got=%b exp=1010", {pbuf, plast}); end
    n_tests++;
    if ({idle, dec_ready, mcu_valid} !== 3'b100) begin n_fail++; $display("FAIL s420_idle got=%b exp=100", {idle, dec_ready, mcu_valid}); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    start_img(2'd1);
    repeat (3) do_block(1'b0);
    n_tests++;
    if ({mcu_valid, wr_buf, mcu_buf, wr_slot} !== 6'b1_1_0_000) begin n_fail++; $display("FAIL same_pre got=%b exp=110000", {mcu_valid, wr_buf, mcu_buf, wr_slot}); end
    repeat (2) do_block(1'b0);
    dec_start = 1'b1;
    tick();
    dec_start = 1'b0; dec_end = 1'b1; mcu_accept = 1'b1;
    tick();
    dec_end = 1'b0; mcu_accept = 1'b0;
    n_tests++;
    if ({mcu_valid, wr_buf, mcu_buf, dec_ready, wr_slot} !== 7'b1_0_1_1_000) begin n_fail++; $display("FAIL same_cycle got=%b exp=1011000", {mcu_valid, wr_buf, mcu_buf, dec_ready, wr_slot}); end
    mcu_accept = 1'b1;
    tick();
    mcu_accept = 1'b0;
    n_tests++;
    if (mcu_valid !== 1'b0) begin n_fail++; $display("FAIL same_occ_one got=%b exp=0", mcu_valid); end
  endtask

  task automatic test_bad_mode();
    do_reset();
    start_img(2'd3);
    n_tests++;
    if ({err, dec_ready, idle} !== 3'b101) begin n_fail++; $display("FAIL badmode_err got=%b exp=101", {err, dec_ready, idle}); end
    tick();
    n_tests++;
    if ({err, dec_ready} !== 2'b10) begin n_fail++; $display("FAIL badmode_hold got=%b exp=10", {err, dec_ready}); end
    start_img(2'd0);
    n_tests++;
    if ({err, dec_ready, idle} !== 3'b010) begin n_fail++; $display("FAIL badmode_clear got=%b exp=010", {err, dec_ready, idle}); end
  endtask

  task automatic test_abort();
    do_reset();
    start_img(2'd2);
    repeat (9) do_block(1'b0);
    n_tests++;
    if ({mcu_valid, wr_slot, wr_buf} !== 5'b1_011_1) begin n_fail++; $display("FAIL abort_pre got=%b exp=10111", {mcu_valid, wr_slot, wr_buf}); end
    start_img(2'd2);
    n_tests++;
    if ({mcu_valid, wr_slot, dec_ready, wr_buf} !== 6'b0_000_1_0) begin n_fail++; $display("FAIL abort_post got=%b exp=000010", {mcu_valid, wr_slot, dec_ready, wr_buf}); end
  endtask

  task automatic test_protocol();
    logic [9:0] obs;
    do_reset();
    start_img(2'd0);
    dec_end = 1'b1;
    tick();
    dec_end = 1'b0;
    n_tests++;
    if ({err, dec_ready, wr_slot, wr_buf, mcu_valid} !== 7'b1_1_000_0_0) begin n_fail++; $display("FAIL proto_end_in_run got=%b exp=1100000", {err, dec_ready, wr_slot, wr_buf, mcu_valid}); end
    do_reset();
    start_img(2'd0);
    do_block(1'b0);
    do_block(1'b0);
    n_tests++;
    if ({err, dec_ready} !== 2'b00) begin n_fail++; $display("FAIL proto_full_clean got=%b exp=00", {err, dec_ready}); end
    dec_start = 1'b1;
    tick();
    dec_start = 1'b0;
    n_tests++;
    if ({err, dec_ready, mcu_valid, wr_buf, mcu_buf} !== 5'b1_0_1_0_0) begin n_fail++; $display("FAIL proto_start_not_ready got=%b exp=10100", {err, dec_ready, mcu_valid, wr_buf, mcu_buf}); end
    do_block(1'b0);
    #2 rst_n = 1'b0;
    #1;
    obs = {dec_ready, wr_buf, wr_slot, mcu_valid, mcu_buf, mcu_last, err, idle};
    n_tests++;
    if (obs !== 10'b0000000001) begin n_fail++; $display("FAIL async_reset got=%b exp=%b", obs, 10'b0000000001); end
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_mono_full();
    test_420_stream();
    test_same_cycle();
    test_bad_mode();
    test_abort();
    test_protocol();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
